// File: rtl/ad9363_if_pkg.sv
// Shared constants and FSM encoding for the AD9363 RX delay calibration block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ad9363_if_pkg;

  localparam int TAP_W    = 5;
  localparam int NUM_TAPS = 32;
  localparam int SAMPLE_W = 12;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_RDY = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_SETTLE   = 3'd3;
  localparam logic [2:0] ST_CHECK    = 3'd4;
  localparam logic [2:0] ST_NEXT     = 3'd5;
  localparam logic [2:0] ST_EVAL     = 3'd6;
  localparam logic [2:0] ST_APPLY    = 3'd7;

endpackage

// File: rtl/ad9363_eye_search.sv
// Serial longest-run-of-ones finder over the per-tap pass map.
// Latency: done pulses NUM_TAPS cycles after start; results hold until the next start.
// Backpressure: none; start is ignored while a scan is in progress.
module ad9363_eye_search
  import ad9363_if_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_TAPS-1:0] pass_map,
  output logic                done,
  output logic [TAP_W-1:0]    best_tap,
  output logic [TAP_W:0]      eye_width
);

  logic                busy;
  logic [NUM_TAPS-1:0] map;
  logic [TAP_W-1:0]    idx;
  logic [TAP_W-1:0]    cur_start;
  logic [TAP_W:0]      cur_len;
  logic [TAP_W-1:0]    best_start;
  logic [TAP_W:0]      best_len;
  logic                bit_now;
  logic [TAP_W:0]      nxt_len;
  logic [TAP_W-1:0]    nxt_start;

  // Extend or break the current run with the bit under the scan pointer.
  always_comb begin
    bit_now   = map[idx];
    nxt_len   = bit_now ? cur_len + 1'b1 : '0;
    nxt_start = (bit_now && cur_len == '0) ? idx : cur_start;
  end

  // Scan one bit per cycle; strict '>' keeps the earliest run on ties, and
  // updating best while a run grows closes a run that ends at the last tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      map        <= '0;
      idx        <= '0;
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy       <= 1'b1;
        map        <= pass_map;
        idx        <= '0;
        cur_start  <= '0;
        cur_len    <= '0;
        best_start <= '0;
        best_len   <= '0;
      end else if (busy) begin
        cur_len   <= nxt_len;
        cur_start <= nxt_start;
        if (nxt_len > best_len) begin
          best_len   <= nxt_len;
          best_start <= nxt_start;
        end
        if (idx == TAP_W'(NUM_TAPS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        idx <= idx + 1'b1;
      end
    end
  end

  // Centre of the winning run, rounding toward the lower tap.
  always_comb begin
    eye_width = best_len;
    best_tap  = '0;
    if (best_len != '0)
      best_tap = best_start + TAP_W'((best_len - 1'b1) >> 1);
  end

endmodule

// File: rtl/ad9363_rx_delay_cal.sv
// Sweeps the RX IDELAY tap against a known AD9363 test pattern and loads the eye centre.
// Latency: per tap 1 load + SETTLE_CYCLES + up to SAMPLES_PER_TAP/TIMEOUT checking; 32-cycle eval.
// Backpressure: none; cal_start/manual_load are dropped while a sweep is busy.
module ad9363_rx_delay_cal
  import ad9363_if_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] PATTERN_I       = 12'hA5A,
  parameter logic [SAMPLE_W-1:0] PATTERN_Q       = 12'h5A5,
  parameter int                  SETTLE_CYCLES   = 64,
  parameter int                  SAMPLES_PER_TAP = 256,
  parameter int                  TIMEOUT_CYCLES  = 4096,
  parameter logic [TAP_W-1:0]    DEFAULT_TAP     = '0
) (
  input  logic                ref_clk,
  input  logic                rst,
  input  logic                idelay_rdy,
  input  logic                cal_start,
  input  logic                manual_load,
  input  logic [TAP_W-1:0]    manual_tap,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data_i1,
  input  logic [SAMPLE_W-1:0] adc_data_q1,
  output logic [TAP_W-1:0]    delay_value,
  output logic                delay_load_en,
  output logic                cal_busy,
  output logic                cal_done,
  output logic                cal_fail,
  output logic [NUM_TAPS-1:0] pass_map,
  output logic [TAP_W-1:0]    best_tap,
  output logic [TAP_W:0]      eye_width
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SMP_W = $clog2(SAMPLES_PER_TAP + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] SAMPLE_LAST  = SMP_W'(SAMPLES_PER_TAP - 1);
  localparam logic [TMO_W-1:0] TIMEOUT_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TAP_W-1:0] LAST_TAP     = TAP_W'(NUM_TAPS - 1);

  state_t           state;
  logic [TAP_W-1:0] tap;
  logic [SET_W-1:0] settle_cnt;
  logic [SMP_W-1:0] sample_cnt;
  logic [TMO_W-1:0] timeout_cnt;
  logic             pattern_ok;
  logic             search_start;
  logic             search_done;
  logic [TAP_W-1:0] search_tap;
  logic [TAP_W:0]   search_width;

  // Sample matches the expected test pattern on both rails.
  always_comb begin
    pattern_ok   = (adc_data_i1 == PATTERN_I) && (adc_data_q1 == PATTERN_Q);
    search_start = (state == ST_NEXT) && (tap == LAST_TAP);
  end

  ad9363_eye_search u_eye_search (
    .clk       (ref_clk),
    .rst       (rst),
    .start     (search_start),
    .pass_map  (pass_map),
    .done      (search_done),
    .best_tap  (search_tap),
    .eye_width (search_width)
  );

  // Calibration FSM, per-tap pattern checker and IDELAY load control.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      tap           <= '0;
      settle_cnt    <= '0;
      sample_cnt    <= '0;
      timeout_cnt   <= '0;
      delay_value   <= '0;
      delay_load_en <= 1'b0;
      cal_busy      <= 1'b0;
      cal_done      <= 1'b0;
      cal_fail      <= 1'b0;
      pass_map      <= '0;
      best_tap      <= '0;
      eye_width     <= '0;
    end else begin
      delay_load_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cal_start) begin
            cal_done <= 1'b0;
            cal_fail <= 1'b0;
            pass_map <= '0;
            tap      <= '0;
            cal_busy <= 1'b1;
            state    <= ST_WAIT_RDY;
          end else if (manual_load && !delay_load_en) begin
            // The guard keeps LD from stretching into the final sweep pulse.
            delay_value   <= manual_tap;
            delay_load_en <= 1'b1;
            best_tap      <= manual_tap;
          end
        end
        ST_WAIT_RDY: begin
          if (idelay_rdy) state <= ST_LOAD;
        end
        ST_LOAD: begin
          delay_value   <= tap;
          delay_load_en <= 1'b1;
          settle_cnt    <= '0;
          state         <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            sample_cnt  <= '0;
            timeout_cnt <= '0;
            state       <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (adc_valid) begin
            if (!pattern_ok) begin
              state <= ST_NEXT;
            end else if (sample_cnt == SAMPLE_LAST) begin
              pass_map[tap] <= 1'b1;
              state         <= ST_NEXT;
            end else begin
              sample_cnt  <= sample_cnt + 1'b1;
              timeout_cnt <= '0;
            end
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state <= ST_NEXT;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (tap == LAST_TAP) begin
            state <= ST_EVAL;
          end else begin
            tap   <= tap + 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_EVAL: begin
          if (search_done) begin
            eye_width <= search_width;
            state     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (eye_width == '0) begin
            delay_value <= DEFAULT_TAP;
            best_tap    <= DEFAULT_TAP;
            cal_fail    <= 1'b1;
          end else begin
            delay_value <= search_tap;
            best_tap    <= search_tap;
            cal_done    <= 1'b1;
          end
          delay_load_en <= 1'b1;
          cal_busy      <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9363_rx_delay_cal.sv
// Directed scoreboard bench: a pattern model plays the AD9363, final loads are checked against a queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_ad9363_rx_delay_cal;

  localparam int SETTLE  = 8;
  localparam int SAMPLES = 16;
  localparam int TIMEOUT = 64;
  localparam int BOUND   = 32 * (2 + SETTLE + TIMEOUT) + 40;

  typedef struct {
    logic [4:0]  dv;
    logic [4:0]  bt;
    logic [5:0]  ew;
    logic [31:0] pm;
    logic        done;
    logic        fail;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, idelay_rdy, cal_start, manual_load, adc_valid;
  logic [4:0]  manual_tap;
  logic [11:0] adc_i, adc_q;
  logic [4:0]  delay_value, best_tap;
  logic        delay_load_en, cal_busy, cal_done, cal_fail;
  logic [31:0] pass_map;
  logic [5:0]  eye_width;

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        q[$];

  logic [31:0] good_mask   = 32'hFFFF_FFFF;
  logic        valid_on    = 1'b1;
  logic        corrupt_en  = 1'b0;
  logic [4:0]  corrupt_tap = 5'd7;
  logic [4:0]  cur_tap     = '0;
  int          mcnt        = 0;

  always #5 clk = ~clk;

  ad9363_rx_delay_cal #(
    .SETTLE_CYCLES   (SETTLE),
    .SAMPLES_PER_TAP (SAMPLES),
    .TIMEOUT_CYCLES  (TIMEOUT)
  ) dut (
    .ref_clk       (clk),
    .rst           (rst),
    .idelay_rdy    (idelay_rdy),
    .cal_start     (cal_start),
    .manual_load   (manual_load),
    .manual_tap    (manual_tap),
    .adc_valid     (adc_valid),
    .adc_data_i1   (adc_i),
    .adc_data_q1   (adc_q),
    .delay_value   (delay_value),
    .delay_load_en (delay_load_en),
    .cal_busy      (cal_busy),
    .cal_done      (cal_done),
    .cal_fail      (cal_fail),
    .pass_map      (pass_map),
    .best_tap      (best_tap),
    .eye_width     (eye_width)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_delay_value"}, 32'(delay_value), 0);
    chk({tag, "_load_en"}, 32'(delay_load_en), 0);
    chk({tag, "_busy"}, 32'(cal_busy), 0);
    chk({tag, "_done"}, 32'(cal_done), 0);
    chk({tag, "_fail"}, 32'(cal_fail), 0);
    chk({tag, "_pass_map"}, pass_map, 0);
    chk({tag, "_best_tap"}, 32'(best_tap), 0);
    chk({tag, "_eye_width"}, 32'(eye_width), 0);
  endtask

  // AD9363 + IDELAY model: tracks the loaded tap, returns the pattern only on good taps.
  initial begin
    logic good;
    adc_valid = 1'b0;
    adc_i     = '0;
    adc_q     = '0;
    forever begin
      @(negedge clk);
      if (delay_load_en) begin
        cur_tap = delay_value;
        mcnt    = 0;
      end else if (mcnt < 100000) begin
        mcnt++;
      end
      good      = good_mask[cur_tap] && !(corrupt_en && cur_tap == corrupt_tap && mcnt == 12);
      adc_valid = valid_on;
      adc_i     = good ? 12'hA5A : 12'h000;
      adc_q     = good ? 12'h5A5 : 12'hFFF;
    end
  end

  // Monitor: sweep loads must step through taps in order; idle loads pop the scoreboard.
  initial begin
    logic       prev_ld = 1'b0;
    logic [4:0] exp_tap = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst || !cal_busy) exp_tap = '0;
      if (delay_load_en) begin
        chk("ld_gap", 32'(prev_ld), 0);
        if (cal_busy) begin
          chk("sweep_tap", 32'(delay_value), 32'(exp_tap));
          exp_tap = exp_tap + 1'b1;
        end else if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_load: got delay_value %0d expected no load", delay_value);
        end else begin
          e = q.pop_front();
          chk("delay_value", 32'(delay_value), 32'(e.dv));
          chk("best_tap", 32'(best_tap), 32'(e.bt));
          chk("eye_width", 32'(eye_width), 32'(e.ew));
          chk("pass_map", pass_map, e.pm);
          chk("cal_done", 32'(cal_done), 32'(e.done));
          chk("cal_fail", 32'(cal_fail), 32'(e.fail));
        end
      end
      prev_ld = delay_load_en;
    end
  end

  task automatic push(input logic [4:0] tap, input logic [5:0] ew, input logic [31:0] pm,
                      input logic done, input logic fail);
    exp_t e;
    e.dv = tap; e.bt = tap; e.ew = ew; e.pm = pm; e.done = done; e.fail = fail;
    q.push_back(e);
  endtask

  // Start a sweep and wait (bounded) for it to finish; optionally poke the ignored strobes.
  task automatic run_cal(input string name, input logic disturb);
    int cyc = 0;
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    while (cal_busy && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      cal_start   = disturb && cyc == 100;
      manual_load = disturb && cyc == 100;
      manual_tap  = 5'd3;
    end
    cal_start   = 1'b0;
    manual_load = 1'b0;
    chk({name, "_within_bound"}, 32'(cyc < BOUND), 1);
    repeat (4) @(negedge clk);
    chk({name, "_scoreboard_drained"}, 32'(q.size()), 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; idelay_rdy = 1'b0; cal_start = 1'b0; manual_load = 1'b0; manual_tap = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk); idelay_rdy = 1'b1;

    good_mask = 32'hFFFF_FFFF;
    push(5'd15, 6'd32, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_cal("all_pass", 1'b0);

    good_mask = 32'h00F0_1FF0;
    push(5'd8, 6'd9, 32'h00F0_1FF0, 1'b1, 1'b0);
    run_cal("two_windows", 1'b0);

    good_mask = 32'h0000_3C3C;
    push(5'd3, 6'd4, 32'h0000_3C3C, 1'b1, 1'b0);
    run_cal("tie_earliest", 1'b0);

    good_mask = 32'hF000_0000;
    push(5'd29, 6'd4, 32'hF000_0000, 1'b1, 1'b0);
    run_cal("run_at_end", 1'b0);

    valid_on = 1'b0;
    push(5'd0, 6'd0, 32'h0, 1'b0, 1'b1);
    run_cal("all_timeout", 1'b0);
    valid_on = 1'b1;

    good_mask  = 32'hFFFF_FFFF;
    corrupt_en = 1'b1;
    push(5'd19, 6'd24, 32'hFFFF_FF7F, 1'b1, 1'b0);
    run_cal("corrupt_tap7", 1'b0);
    corrupt_en = 1'b0;

    // Abort mid-CHECK at tap 10: no final load, everything back to zero.
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    cyc = 0;
    while (!(cal_busy && cur_tap == 5'd10 && mcnt == 12) && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_tap10", 32'(cyc < BOUND), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    push(5'd17, 6'd0, 32'h0, 1'b0, 1'b0);
    manual_tap = 5'd17; manual_load = 1'b1;
    @(negedge clk); manual_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("manual_drained", 32'(q.size()), 0);

    push(5'd15, 6'd32, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_cal("busy_ignores_strobes", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
